event_packetizer: RTL

Downstream stage of the 16x16 pixel arbiter. It consumes each granted event from the arbiter's `data_out_o`, plus the group-release strobe, and tags every event with a free-running timestamp. Tagged words are buffered in a 16-deep FIFO and presented to the readout link on a valid/ready handshake. Drops caused by FIFO overflow are counted and reported in-band with a marker word.

---
 rtl/lib_arbiter_pkg.sv | 31 +++
 rtl/sync_fifo.sv | 68 ++++++
 rtl/event_packetizer.sv | 110 +++++++++++
 3 files changed

// File: rtl/lib_arbiter_pkg.sv
// ============================================================================
// Module      : lib_arbiter_pkg
// Description : Shared types and constants for the pixel arbiter and the
//               downstream event packetizer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lib_arbiter_pkg;

  localparam int WIDTH     = 10;
  localparam int TS_W      = 16;
  localparam int OUT_W     = 2 + TS_W + WIDTH;
  localparam int PKT_DEPTH = 16;

  typedef enum logic [1:0] {
    EVT      = 2'b00,
    EVT_LAST = 2'b01,
    GRP      = 2'b10,
    DROP     = 2'b11
  } pkt_type_e;

  typedef struct packed {
    pkt_type_e         ptype;
    logic [TS_W-1:0]   ts;
    logic [WIDTH-1:0]  payload;
  } pkt_word_t;

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock show-ahead FIFO with registered full/empty/level.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
  parameter  int W     = 28,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          push_i,
  input  logic [W-1:0]  data_i,
  input  logic          pop_i,
  output logic [W-1:0]  data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic          w_push;
  logic          w_pop;

  assign full_o  = (r_level == (AW+1)'(DEPTH));
  assign empty_o = (r_level == '0);
  assign level_o = r_level;
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;

  // Head is masked while empty so the output is clean through reset
  assign data_o  = empty_o ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/event_packetizer.sv
// ============================================================================
// Module      : event_packetizer
// Description : Timestamps arbiter events / group releases, buffers them in a
//               FIFO and reports overflow drops in-band with DROP words.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module event_packetizer #(
  parameter  int WIDTH = lib_arbiter_pkg::WIDTH,
  parameter  int TS_W  = lib_arbiter_pkg::TS_W,
  parameter  int DEPTH = lib_arbiter_pkg::PKT_DEPTH,
  parameter  int OUT_W = 2 + TS_W + WIDTH,
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              evt_valid_i,
  input  logic [WIDTH-1:0]  evt_data_i,
  input  logic              grp_release_i,
  output logic              pkt_valid_o,
  input  logic              pkt_ready_i,
  output logic [OUT_W-1:0]  pkt_data_o,
  output logic [LVL_W-1:0]  fifo_level_o,
  output logic              overflow_o,
  output logic [15:0]       drop_total_o
);

  import lib_arbiter_pkg::*;

  logic [TS_W-1:0]  r_ts;
  logic [WIDTH-1:0] r_drop_cnt;
  logic             r_pending;
  logic [15:0]      r_drop_total;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_item;
  logic             w_space;
  logic             w_drop_slot;
  logic             w_drop_item;
  pkt_type_e        w_item_type;
  logic [WIDTH-1:0] w_item_payload;
  logic [OUT_W-1:0] w_word;

  assign pkt_valid_o  = ~w_empty;
  assign w_pop        = pkt_valid_o & pkt_ready_i;
  assign overflow_o   = r_pending;
  assign drop_total_o = r_drop_total;

  always_comb begin
    w_item         = evt_valid_i | grp_release_i;
    w_space        = ~w_full;
    w_drop_slot    = r_pending & w_space;
    // An item is lost when the FIFO is full or a pending marker takes the slot
    w_drop_item    = w_item & (~w_space | r_pending);
    w_item_type    = GRP;
    w_item_payload = '0;
    if (evt_valid_i) begin
      w_item_type    = grp_release_i ? EVT_LAST : EVT;
      w_item_payload = evt_data_i;
    end
    w_push = w_drop_slot | (w_item & w_space);
    w_word = w_drop_slot ? {DROP, r_ts, r_drop_cnt}
                         : {w_item_type, r_ts, w_item_payload};
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      r_ts         <= '0;
      r_drop_cnt   <= '0;
      r_pending    <= 1'b0;
      r_drop_total <= '0;
    end else begin
      r_ts <= r_ts + 1'b1;
      if (w_drop_slot) begin
        r_pending  <= w_drop_item;
        r_drop_cnt <= w_drop_item ? {{(WIDTH-1){1'b0}}, 1'b1} : '0;
      end else if (w_drop_item) begin
        r_pending <= 1'b1;
        if (r_drop_cnt != '1) begin
          r_drop_cnt <= r_drop_cnt + 1'b1;
        end
      end
      if (w_drop_item && (r_drop_total != '1)) begin
        r_drop_total <= r_drop_total + 1'b1;
      end
    end
  end

  sync_fifo #(
    .W     (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .push_i   (w_push),
    .data_i   (w_word),
    .pop_i    (w_pop),
    .data_o   (pkt_data_o),
    .full_o   (w_full),
    .empty_o  (w_empty),
    .level_o  (fifo_level_o)
  );

endmodule

`default_nettype wire
